// File: rtl/rs_scalable.sv
// Parametrised reservation station: multi-slot dispatch with CDB wakeup, and
// oldest-first multi-slot issue ordered by a pairwise age matrix.
module rs_scalable #(
  parameter int DEPTH     = 16,
  parameter int DISP_W    = 3,
  parameter int ISSUE_W   = 3,
  parameter int CDB_W     = 3,
  parameter int TAG_W     = 6,
  parameter int PAYLOAD_W = 64
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           flush,
  input  logic [DISP_W-1:0]              disp_valid,
  input  logic [DISP_W*TAG_W-1:0]        disp_dest,
  input  logic [DISP_W*TAG_W-1:0]        disp_src1,
  input  logic [DISP_W*TAG_W-1:0]        disp_src2,
  input  logic [DISP_W-1:0]              disp_src1_rdy,
  input  logic [DISP_W-1:0]              disp_src2_rdy,
  input  logic [DISP_W*PAYLOAD_W-1:0]    disp_payload,
  output logic [DISP_W-1:0]              dispatch_stall,
  output logic [$clog2(DEPTH):0]         free_count,
  input  logic [CDB_W-1:0]               cdb_valid,
  input  logic [CDB_W*TAG_W-1:0]         cdb_tag,
  output logic [ISSUE_W-1:0]             issue_valid,
  input  logic [ISSUE_W-1:0]             issue_ready,
  output logic [ISSUE_W*TAG_W-1:0]       issue_dest,
  output logic [ISSUE_W*TAG_W-1:0]       issue_src1,
  output logic [ISSUE_W*TAG_W-1:0]       issue_src2,
  output logic [ISSUE_W*PAYLOAD_W-1:0]   issue_payload
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  // Handshake: issue slot k transfers its entry at the rising edge when
  // issue_valid[k] && issue_ready[k]; issue_valid never depends on issue_ready.

  logic [DEPTH-1:0]     valid_q;
  logic [DEPTH-1:0]     s1_rdy_q;
  logic [DEPTH-1:0]     s2_rdy_q;
  logic [TAG_W-1:0]     dest_q    [DEPTH];
  logic [TAG_W-1:0]     src1_q    [DEPTH];
  logic [TAG_W-1:0]     src2_q    [DEPTH];
  logic [PAYLOAD_W-1:0] payload_q [DEPTH];
  // older_q[i][j] = 1 means entry i is older than entry j
  logic [DEPTH-1:0]     older_q   [DEPTH];
  logic [DEPTH-1:0]     older_d   [DEPTH];

  logic [DEPTH-1:0]     alloc_taken;
  logic [DISP_W-1:0]    alloc_en;
  logic [IDX_W-1:0]     alloc_idx [DISP_W];
  logic [DEPTH-1:0]     alloc_oh  [DISP_W];
  logic [DEPTH-1:0]     younger_mask;
  logic [DEPTH-1:0]     elder_mask;

  logic [DEPTH-1:0]     elig;
  logic [CNT_W-1:0]     rank      [DEPTH];
  logic [DEPTH-1:0]     remove;
  logic [CNT_W-1:0]     n_alloc;
  logic [CNT_W-1:0]     n_remove;

  function automatic logic cdb_hit(input logic [TAG_W-1:0]       tag,
                                   input logic [CDB_W-1:0]       cv,
                                   input logic [CDB_W*TAG_W-1:0] ct);
    cdb_hit = 1'b0;
    for (int c = 0; c < CDB_W; c++) begin
      if (cv[c] && (ct[c*TAG_W +: TAG_W] == tag)) cdb_hit = 1'b1;
    end
  endfunction

  always_comb begin
    for (int j = 0; j < DISP_W; j++) begin
      dispatch_stall[j] = (free_count <= CNT_W'(j));
    end
  end

  // Each active slot takes the lowest free entry left by lower slots.
  // Entries freed by issue this cycle are still marked valid here.
  always_comb begin
    alloc_taken = valid_q;
    n_alloc     = '0;
    for (int j = 0; j < DISP_W; j++) begin
      alloc_en[j]  = 1'b0;
      alloc_idx[j] = '0;
      alloc_oh[j]  = '0;
      if (disp_valid[j] && !dispatch_stall[j] && !flush) begin
        for (int i = DEPTH - 1; i >= 0; i--) begin
          if (!alloc_taken[i]) begin
            alloc_en[j]  = 1'b1;
            alloc_idx[j] = IDX_W'(i);
          end
        end
        if (alloc_en[j]) begin
          alloc_oh[j][alloc_idx[j]]    = 1'b1;
          alloc_taken[alloc_idx[j]]    = 1'b1;
          n_alloc                      = n_alloc + CNT_W'(1);
        end
      end
    end
  end

  // New entries are younger than every existing entry and than lower slots.
  always_comb begin
    older_d      = older_q;
    younger_mask = '0;
    elder_mask   = '0;
    for (int j = 0; j < DISP_W; j++) begin
      if (alloc_en[j]) begin
        younger_mask = '0;
        elder_mask   = valid_q;
        for (int jj = 0; jj < DISP_W; jj++) begin
          if (jj > j) younger_mask = younger_mask | alloc_oh[jj];
          if (jj < j) elder_mask   = elder_mask | alloc_oh[jj];
        end
        older_d[alloc_idx[j]] = younger_mask;
        for (int m = 0; m < DEPTH; m++) begin
          older_d[m][alloc_idx[j]] = elder_mask[m];
        end
      end
    end
  end

  // Rank of an eligible entry = number of eligible entries older than it.
  always_comb begin
    elig = valid_q & s1_rdy_q & s2_rdy_q;
    for (int i = 0; i < DEPTH; i++) begin
      rank[i] = '0;
      for (int j = 0; j < DEPTH; j++) begin
        if (elig[j] && older_q[j][i]) rank[i] = rank[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    issue_valid   = '0;
    issue_dest    = '0;
    issue_src1    = '0;
    issue_src2    = '0;
    issue_payload = '0;
    remove        = '0;
    n_remove      = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!flush && elig[i] && (rank[i] == CNT_W'(k))) begin
          issue_valid[k]                          = 1'b1;
          issue_dest[k*TAG_W +: TAG_W]            = dest_q[i];
          issue_src1[k*TAG_W +: TAG_W]            = src1_q[i];
          issue_src2[k*TAG_W +: TAG_W]            = src2_q[i];
          issue_payload[k*PAYLOAD_W +: PAYLOAD_W] = payload_q[i];
          if (issue_ready[k]) begin
            remove[i] = 1'b1;
            n_remove  = n_remove + CNT_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q    <= '0;
      s1_rdy_q   <= '0;
      s2_rdy_q   <= '0;
      free_count <= CNT_W'(DEPTH);
      for (int i = 0; i < DEPTH; i++) begin
        dest_q[i]    <= '0;
        src1_q[i]    <= '0;
        src2_q[i]    <= '0;
        payload_q[i] <= '0;
        older_q[i]   <= '0;
      end
    end else begin
      older_q    <= older_d;
      free_count <= flush ? CNT_W'(DEPTH) : (free_count + n_remove - n_alloc);
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i]) begin
          if (cdb_hit(src1_q[i], cdb_valid, cdb_tag)) s1_rdy_q[i] <= 1'b1;
          if (cdb_hit(src2_q[i], cdb_valid, cdb_tag)) s2_rdy_q[i] <= 1'b1;
        end
        if (flush || remove[i]) valid_q[i] <= 1'b0;
      end
      // Incoming sources also see the same-cycle CDB; tag 0 is always ready.
      for (int j = 0; j < DISP_W; j++) begin
        if (alloc_en[j]) begin
          valid_q[alloc_idx[j]]   <= 1'b1;
          dest_q[alloc_idx[j]]    <= disp_dest[j*TAG_W +: TAG_W];
          src1_q[alloc_idx[j]]    <= disp_src1[j*TAG_W +: TAG_W];
          src2_q[alloc_idx[j]]    <= disp_src2[j*TAG_W +: TAG_W];
          payload_q[alloc_idx[j]] <= disp_payload[j*PAYLOAD_W +: PAYLOAD_W];
          s1_rdy_q[alloc_idx[j]]  <= disp_src1_rdy[j]
                                     || (disp_src1[j*TAG_W +: TAG_W] == '0)
                                     || cdb_hit(disp_src1[j*TAG_W +: TAG_W], cdb_valid, cdb_tag);
          s2_rdy_q[alloc_idx[j]]  <= disp_src2_rdy[j]
                                     || (disp_src2[j*TAG_W +: TAG_W] == '0)
                                     || cdb_hit(disp_src2[j*TAG_W +: TAG_W], cdb_valid, cdb_tag);
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_scalable.sv
// Bench for rs_scalable: directed vector table, reset/flush sequences and
// random traffic checked against an age-ordered queue model.
module tb_rs_scalable;

  localparam int DEPTH     = 16;
  localparam int DISP_W    = 3;
  localparam int ISSUE_W   = 3;
  localparam int CDB_W     = 3;
  localparam int TAG_W     = 6;
  localparam int PAYLOAD_W = 64;
  localparam int CNT_W     = 5;

  logic                         clock;
  logic                         reset;
  logic                         flush;
  logic [DISP_W-1:0]            disp_valid;
  logic [DISP_W*TAG_W-1:0]      disp_dest;
  logic [DISP_W*TAG_W-1:0]      disp_src1;
  logic [DISP_W*TAG_W-1:0]      disp_src2;
  logic [DISP_W-1:0]            disp_src1_rdy;
  logic [DISP_W-1:0]            disp_src2_rdy;
  logic [DISP_W*PAYLOAD_W-1:0]  disp_payload;
  logic [DISP_W-1:0]            dispatch_stall;
  logic [CNT_W-1:0]             free_count;
  logic [CDB_W-1:0]             cdb_valid;
  logic [CDB_W*TAG_W-1:0]       cdb_tag;
  logic [ISSUE_W-1:0]           issue_valid;
  logic [ISSUE_W-1:0]           issue_ready;
  logic [ISSUE_W*TAG_W-1:0]     issue_dest;
  logic [ISSUE_W*TAG_W-1:0]     issue_src1;
  logic [ISSUE_W*TAG_W-1:0]     issue_src2;
  logic [ISSUE_W*PAYLOAD_W-1:0] issue_payload;

  rs_scalable #(
    .DEPTH(DEPTH), .DISP_W(DISP_W), .ISSUE_W(ISSUE_W), .CDB_W(CDB_W),
    .TAG_W(TAG_W), .PAYLOAD_W(PAYLOAD_W)
  ) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .disp_valid(disp_valid), .disp_dest(disp_dest),
    .disp_src1(disp_src1), .disp_src2(disp_src2),
    .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
    .disp_payload(disp_payload), .dispatch_stall(dispatch_stall),
    .free_count(free_count), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_dest(issue_dest), .issue_src1(issue_src1), .issue_src2(issue_src2),
    .issue_payload(issue_payload)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- model and scoreboard ----------------
  typedef struct {
    logic [TAG_W-1:0]     dest;
    logic [TAG_W-1:0]     src1;
    logic [TAG_W-1:0]     src2;
    logic                 r1;
    logic                 r2;
    logic [PAYLOAD_W-1:0] payload;
  } ent_t;

  typedef struct {
    logic [2:0] dv;
    logic [5:0] s1;
    logic [5:0] s2;
    logic [2:0] cv;
    logic [5:0] ct;
    logic [2:0] ir;
    logic       fl;
    logic [2:0] e_iv;
    logic [4:0] e_fc;
    logic [2:0] e_st;
  } vec_t;

  ent_t                 model_q[$];   // oldest first
  logic [PAYLOAD_W-1:0] exp_q[$];     // payloads expected to be accepted
  vec_t                 tab[$];
  vec_t                 cur_v;
  int                   cur_row;
  logic                 tab_on;
  int                   total;
  int                   bad;
  int                   uid;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic m_hit(input logic [TAG_W-1:0] tag);
    m_hit = 1'b0;
    for (int c = 0; c < CDB_W; c++) begin
      if (cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == tag) m_hit = 1'b1;
    end
  endfunction

  // Compare outputs against the model, then advance the model one edge.
  task automatic check_and_advance();
    int   fc;
    int   sel[$];
    logic [DISP_W-1:0]  st;
    logic [ISSUE_W-1:0] iv;
    ent_t e;
    fc = DEPTH - model_q.size();
    for (int j = 0; j < DISP_W; j++) st[j] = (fc <= j);
    iv = '0;
    if (!flush) begin
      for (int i = 0; i < model_q.size(); i++) begin
        if (model_q[i].r1 && model_q[i].r2 && sel.size() < ISSUE_W) sel.push_back(i);
      end
    end
    for (int k = 0; k < sel.size(); k++) iv[k] = 1'b1;
    chk("stall", dispatch_stall, st);
    chk("free_count", free_count, fc);
    chk("issue_valid", issue_valid, iv);
    for (int k = 0; k < sel.size(); k++) begin
      e = model_q[sel[k]];
      chk($sformatf("slot%0d", k),
          {issue_dest[k*TAG_W +: TAG_W], issue_src1[k*TAG_W +: TAG_W],
           issue_src2[k*TAG_W +: TAG_W], issue_payload[k*PAYLOAD_W +: PAYLOAD_W]},
          {e.dest, e.src1, e.src2, e.payload});
      if (issue_ready[k]) exp_q.push_back(e.payload);
    end
    for (int k = 0; k < ISSUE_W; k++) begin
      if (issue_valid[k] && issue_ready[k]) begin
        if (exp_q.size() > 0) begin
          chk("accept", issue_payload[k*PAYLOAD_W +: PAYLOAD_W], exp_q.pop_front());
        end else begin
          total++;
          bad++;
          $display("FAIL accept_extra: got slot %0d accepted want none", k);
        end
      end
    end
    for (int k = sel.size() - 1; k >= 0; k--) begin
      if (issue_ready[k]) model_q.delete(sel[k]);
    end
    for (int i = 0; i < model_q.size(); i++) begin
      if (m_hit(model_q[i].src1)) model_q[i].r1 = 1'b1;
      if (m_hit(model_q[i].src2)) model_q[i].r2 = 1'b1;
    end
    if (!flush) begin
      for (int j = 0; j < DISP_W; j++) begin
        if (disp_valid[j] && j < fc) begin
          e.dest    = disp_dest[j*TAG_W +: TAG_W];
          e.src1    = disp_src1[j*TAG_W +: TAG_W];
          e.src2    = disp_src2[j*TAG_W +: TAG_W];
          e.r1      = disp_src1_rdy[j] || e.src1 == 0 || m_hit(e.src1);
          e.r2      = disp_src2_rdy[j] || e.src2 == 0 || m_hit(e.src2);
          e.payload = disp_payload[j*PAYLOAD_W +: PAYLOAD_W];
          model_q.push_back(e);
        end
      end
    end else begin
      model_q.delete();
    end
  endtask

  // One cycle: inputs already driven; check mid-cycle, then advance.
  task automatic step();
    @(negedge clock);
    if (tab_on) begin
      chk($sformatf("row%0d_iv", cur_row), issue_valid, cur_v.e_iv);
      chk($sformatf("row%0d_fc", cur_row), free_count, cur_v.e_fc);
      chk($sformatf("row%0d_st", cur_row), dispatch_stall, cur_v.e_st);
    end
    check_and_advance();
    @(posedge clock);
    #1;
  endtask

  // ---------------- drivers ----------------
  task automatic drive_idle();
    disp_valid = '0; disp_dest = '0; disp_src1 = '0; disp_src2 = '0;
    disp_src1_rdy = '0; disp_src2_rdy = '0; disp_payload = '0;
    cdb_valid = '0; cdb_tag = '0; issue_ready = '0; flush = 1'b0;
  endtask

  task automatic drive_disp(input logic [2:0] dv, input logic [5:0] s1, input logic [5:0] s2);
    disp_valid = dv;
    disp_src1_rdy = '0;
    disp_src2_rdy = '0;
    for (int j = 0; j < DISP_W; j++) begin
      disp_dest[j*TAG_W +: TAG_W]            = TAG_W'(uid);
      disp_src1[j*TAG_W +: TAG_W]            = s1;
      disp_src2[j*TAG_W +: TAG_W]            = s2;
      disp_payload[j*PAYLOAD_W +: PAYLOAD_W] = {32'(uid), $urandom()};
      uid++;
    end
  endtask

  function automatic vec_t mk(input logic [2:0] dv, input logic [5:0] s1, input logic [5:0] s2,
                              input logic [2:0] cv, input logic [5:0] ct, input logic [2:0] ir,
                              input logic fl, input logic [2:0] e_iv, input logic [4:0] e_fc,
                              input logic [2:0] e_st);
    vec_t v;
    v.dv = dv; v.s1 = s1; v.s2 = s2; v.cv = cv; v.ct = ct; v.ir = ir; v.fl = fl;
    v.e_iv = e_iv; v.e_fc = e_fc; v.e_st = e_st;
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_iv"}, issue_valid, 0);
    chk({tag, "_fc"}, free_count, DEPTH);
    chk({tag, "_st"}, dispatch_stall, 0);
    chk({tag, "_tags"}, {issue_dest, issue_src1, issue_src2}, 0);
    chk({tag, "_pay"}, issue_payload, 0);
  endtask

  // ---------------- test ----------------
  initial begin
    total = 0; bad = 0; uid = 1; tab_on = 1'b0; cur_row = 0;
    reset = 1'b0;
    drive_idle();
    @(posedge clock);
    #1;
    check_reset_outputs("reset");
    @(posedge clock);
    #1;
    reset = 1'b1;

    //          dv    s1 s2 cv ct ir  fl   iv    fc  st
    tab.push_back(mk(3'd0, 0, 0, 0, 0, 0, 0, 3'd0, 16, 3'd0));
    tab.push_back(mk(3'd7, 0, 0, 0, 0, 0, 0, 3'd0, 16, 3'd0));
    tab.push_back(mk(3'd0, 0, 0, 0, 0, 7, 0, 3'd7, 13, 3'd0));
    tab.push_back(mk(3'd0, 0, 0, 0, 0, 0, 0, 3'd0, 16, 3'd0));
    tab.push_back(mk(3'd7, 5, 0, 0, 0, 0, 0, 3'd0, 16, 3'd0));
    tab.push_back(mk(3'd7, 5, 0, 0, 0, 0, 0, 3'd0, 13, 3'd0));
    tab.push_back(mk(3'd7, 5, 0, 0, 0, 0, 0, 3'd0, 10, 3'd0));
    tab.push_back(mk(3'd7, 5, 0, 0, 0, 0, 0, 3'd0,  7, 3'd0));
    tab.push_back(mk(3'd7, 5, 0, 0, 0, 0, 0, 3'd0,  4, 3'd0));
    tab.push_back(mk(3'd1, 5, 0, 0, 0, 0, 0, 3'd0,  1, 3'b110));
    tab.push_back(mk(3'd7, 5, 0, 1, 5, 0, 0, 3'd0,  0, 3'd7));
    tab.push_back(mk(3'd0, 0, 0, 0, 0, 0, 0, 3'd7,  0, 3'd7));
    tab.push_back(mk(3'd0, 0, 0, 0, 0, 7, 0, 3'd7,  0, 3'd7));
    tab.push_back(mk(3'd0, 0, 0, 0, 0, 7, 0, 3'd7,  3, 3'd0));
    tab.push_back(mk(3'd0, 0, 0, 0, 0, 7, 0, 3'd7,  6, 3'd0));
    tab.push_back(mk(3'd0, 0, 0, 0, 0, 7, 0, 3'd7,  9, 3'd0));
    tab.push_back(mk(3'd0, 0, 0, 0, 0, 7, 0, 3'd7, 12, 3'd0));
    tab.push_back(mk(3'd0, 0, 0, 0, 0, 7, 0, 3'd1, 15, 3'd0));
    tab.push_back(mk(3'd0, 0, 0, 0, 0, 0, 0, 3'd0, 16, 3'd0));
    tab.push_back(mk(3'd7, 5, 0, 0, 0, 0, 0, 3'd0, 16, 3'd0));
    tab.push_back(mk(3'd7, 5, 0, 0, 0, 0, 0, 3'd0, 13, 3'd0));
    tab.push_back(mk(3'd7, 5, 0, 0, 0, 0, 0, 3'd0, 10, 3'd0));
    tab.push_back(mk(3'd7, 5, 0, 0, 0, 0, 0, 3'd0,  7, 3'd0));
    tab.push_back(mk(3'd3, 5, 0, 0, 0, 0, 0, 3'd0,  4, 3'd0));
    tab.push_back(mk(3'd7, 5, 0, 0, 0, 0, 0, 3'd0,  2, 3'b100));
    tab.push_back(mk(3'd0, 0, 0, 0, 0, 0, 0, 3'd0,  0, 3'd7));
    tab.push_back(mk(3'd0, 0, 0, 1, 5, 0, 1, 3'd0,  0, 3'd7));
    tab.push_back(mk(3'd0, 0, 0, 0, 0, 0, 0, 3'd0, 16, 3'd0));
    tab.push_back(mk(3'd1, 0, 9, 1, 9, 0, 0, 3'd0, 16, 3'd0));
    tab.push_back(mk(3'd0, 0, 0, 0, 0, 0, 0, 3'd1, 15, 3'd0));
    tab.push_back(mk(3'd0, 0, 0, 0, 0, 1, 0, 3'd1, 15, 3'd0));
    tab.push_back(mk(3'd0, 0, 0, 0, 0, 0, 0, 3'd0, 16, 3'd0));
    tab.push_back(mk(3'd7, 0, 0, 0, 0, 0, 0, 3'd0, 16, 3'd0));
    tab.push_back(mk(3'd1, 0, 0, 0, 0, 0, 0, 3'd7, 13, 3'd0));
    tab.push_back(mk(3'd0, 0, 0, 0, 0, 2, 0, 3'd7, 12, 3'd0));
    tab.push_back(mk(3'd0, 0, 0, 0, 0, 0, 0, 3'd7, 13, 3'd0));
    tab.push_back(mk(3'd0, 0, 0, 0, 0, 7, 0, 3'd7, 13, 3'd0));
    tab.push_back(mk(3'd0, 0, 0, 0, 0, 0, 0, 3'd0, 16, 3'd0));

    tab_on = 1'b1;
    for (int r = 0; r < tab.size(); r++) begin
      cur_row = r;
      cur_v   = tab[r];
      drive_idle();
      drive_disp(cur_v.dv, cur_v.s1, cur_v.s2);
      cdb_valid   = cur_v.cv;
      cdb_tag     = {3{cur_v.ct}};
      issue_ready = cur_v.ir;
      flush       = cur_v.fl;
      step();
    end
    tab_on = 1'b0;

    // Asynchronous reset in the middle of operation with 7 waiting entries.
    drive_idle(); drive_disp(3'd7, 5, 0); step();
    drive_idle(); drive_disp(3'd7, 5, 0); step();
    drive_idle(); drive_disp(3'd1, 5, 0); step();
    drive_idle();
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_q.delete();
    @(posedge clock);
    #1;
    reset = 1'b1;
    step();

    // Flush with 7 entries, some eligible.
    drive_idle(); drive_disp(3'd7, 0, 0); step();
    drive_idle(); drive_disp(3'd7, 0, 0); step();
    drive_idle(); drive_disp(3'd1, 0, 0); step();
    drive_idle(); flush = 1'b1; issue_ready = 3'd7; step();
    drive_idle(); step();
    chk("post_flush_fc", free_count, DEPTH);
    chk("post_flush_iv", issue_valid, 0);

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      drive_idle();
      disp_valid = DISP_W'($urandom());
      for (int j = 0; j < DISP_W; j++) begin
        disp_dest[j*TAG_W +: TAG_W]            = TAG_W'($urandom());
        disp_src1[j*TAG_W +: TAG_W]            = TAG_W'($urandom_range(0, 7));
        disp_src2[j*TAG_W +: TAG_W]            = TAG_W'($urandom_range(0, 7));
        disp_src1_rdy[j]                       = ($urandom_range(0, 3) == 0);
        disp_src2_rdy[j]                       = ($urandom_range(0, 3) == 0);
        disp_payload[j*PAYLOAD_W +: PAYLOAD_W] = {$urandom(), $urandom()};
      end
      for (int c = 0; c < CDB_W; c++) begin
        cdb_valid[c]               = ($urandom_range(0, 1) == 0);
        cdb_tag[c*TAG_W +: TAG_W]  = TAG_W'($urandom_range(1, 7));
      end
      issue_ready = ISSUE_W'($urandom());
      flush       = ($urandom_range(0, 63) == 0);
      step();
    end

    chk("exp_q_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rs_scalable.md
Name: rs_scalable

Overview:
Parametrised reservation station, successor to the fixed 3-wide RS. Accepts up to DISP_W renamed instructions per cycle and holds them until their source tags are woken by the CDB. Issues up to ISSUE_W ready entries per cycle in oldest-first order, tracked by an age matrix. Adds a full-flush input. Sits between dispatch/rename and the FU issue stage.

Parameters:
DEPTH, 16, number of entries (power of 2, at least 4)
DISP_W, 3, dispatch slots per cycle
ISSUE_W, 3, issue slots per cycle
CDB_W, 3, CDB tag broadcasts per cycle
TAG_W, 6, physical register tag width; tag 0 is the zero register and is always ready
PAYLOAD_W, 64, opaque per-instruction payload (op, PC, imm, FU select, …)

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (asserted when 0)
flush  input  1  squash all entries at next edge
disp_valid  input  DISP_W  dispatch request per slot; slot 0 is oldest in program order
disp_dest  input  DISP_W*TAG_W  destination tags
disp_src1, disp_src2  input  DISP_W*TAG_W  source tags
disp_src1_rdy, disp_src2_rdy  input  DISP_W  source ready at rename
disp_payload  input  DISP_W*PAYLOAD_W  payload
dispatch_stall  output  DISP_W  slot j must not dispatch this cycle
free_count  output  $clog2(DEPTH)+1  registered count of invalid entries
cdb_valid  input  CDB_W  broadcast valid
cdb_tag  input  CDB_W*TAG_W  completing tags
issue_valid  output  ISSUE_W  issue slot k holds an entry
issue_ready  input  ISSUE_W  FU accepts slot k this cycle
issue_dest, issue_src1, issue_src2  output  ISSUE_W*TAG_W  tags of issued entry
issue_payload  output  ISSUE_W*PAYLOAD_W  payload of issued entry

Behaviour:
- Reset (async, reset=0): all entries invalid, age matrix cleared; outputs: issue_valid=0, dispatch_stall=0, free_count=DEPTH, other outputs 0.
- Entry state: valid, dest, src1/src2 tag + ready bit, payload; age bit older[i][j] for every pair.
- Stall: dispatch_stall[j]=1 iff free_count<=j. Derived from registered state only. Entries freed by issue this cycle are not reusable until the next cycle, so there is no combinational path from issue_ready to stall.
- Allocation: each valid, unstalled slot takes the lowest-index free entry remaining after lower-numbered slots have allocated. Invalid slots consume no entry. Slots at or above a stalled slot are ignored even if valid.
- Age: a new entry is younger than all existing valid entries. Among entries allocated in the same cycle, a lower slot index is older.
- Wakeup: each edge, a src ready bit sets if its tag equals any valid cdb_tag. Dispatch-cycle bypass: an incoming source is also compared against the same-cycle CDB, so it is stored ready if matched. Tag 0 is ready on entry, whatever the rdy input.
- Eligibility: valid, src1 ready, src2 ready (registered bits). CDB wakeup makes an entry eligible next cycle, never the same cycle.
- Select: slot k presents the (k+1)-th oldest eligible entry; issue_valid[k]=0 if fewer eligible entries exist. Selection does not depend on issue_ready.
- Removal: an entry is invalidated at the edge iff its slot has issue_valid[k] and issue_ready[k] both 1. Unaccepted entries stay, keep their age, and are re-presented next cycle, possibly in a different slot.
- flush=1: all entries invalid at the edge; dispatches that cycle are dropped; issue_valid forced to 0 that cycle. free_count=DEPTH the next cycle.
- Simultaneous events: dispatch into a free entry and removal of another entry in the same cycle are independent. A CDB hit on an entry being removed has no effect.
- free_count updates each edge: free_count + removed − allocated.
- Outputs on the issue side are combinational from registered state. dispatch_stall and free_count are registered-derived.

Test Plan:
- Reset, then dispatch 3 instructions with all sources ready (src tags 0) -> the next cycle issue_valid=3'b111 in slot order 0,1,2; after issue_ready=3'b111, free_count returns to 16.
- Fill 16 entries with src1=5, not ready -> free_count=0, dispatch_stall=3'b111, issue_valid=0. Broadcast cdb_tag=5 -> the next cycle the 3 oldest entries (entries 0..2) issue.
- free_count=2 -> dispatch_stall=3'b100; dispatch 3 valid slots -> only slots 0 and 1 are allocated.
- Dispatch src2=9 (rdy=0) in the same cycle as cdb_tag=9 -> the entry issues the next cycle (bypass is not lost).
- Four ready entries with issue_ready=3'b010 -> only the second-oldest is removed; the next cycle the oldest is again in slot 0.
- Hold reset=0 mid-operation with 7 valid entries, then flush=1 in a separate run -> 0 valid, free_count=16, issue_valid=0 in both cases.
